// File: rtl/bcd_pkg.sv
// Shared types, digit limits and the nibble clamp used by the BCD down counter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // Any nibble above 9 is treated as 9 so a bad load can never leave a non-BCD digit.
  function automatic bcd_digit_t bcd_sat(input logic [3:0] nib);
    if (nib > BCD_MAX) begin
      return BCD_MAX;
    end else begin
      return nib;
    end
  endfunction

endpackage

// File: rtl/m10_down_digit.sv
// One mod-10 down-counting BCD digit; wrap_val is the value taken when decrementing from 0.
module m10_down_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dec,
  input  logic       load,
  input  logic [3:0] ld_val,
  input  logic [3:0] wrap_val,
  output logic [3:0] digit,
  output logic       is_zero
);

  bcd_digit_t digit_q;
  bcd_digit_t digit_d;

  // Next digit value: load beats decrement, decrement beats hold.
  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = ld_val;
    end else if (dec) begin
      if (digit_q == BCD_MIN) begin
        digit_d = wrap_val;
      end else begin
        digit_d = digit_q - 4'd1;
      end
    end else begin
      digit_d = digit_q;
    end
  end

  // Digit state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= BCD_MIN;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit   = digit_q;
  assign is_zero = (digit_q == BCD_MIN);

endmodule

// File: rtl/bcd_down_counter.sv
// Cascadable multi-digit BCD down counter with zero flag, underflow borrow pulse,
// load-error pulse and optional reload of the last loaded value on underflow.
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS      = 2,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  zero,
  output logic                  borrow,
  output logic                  load_err
);

  logic [DIGITS-1:0]   is_zero;
  logic [DIGITS-1:0]   dec;
  logic [DIGITS-1:0]   nib_bad;
  logic [4*DIGITS-1:0] ld_sat;
  logic [4*DIGITS-1:0] reload_q;
  logic [4*DIGITS-1:0] reload_d;
  logic                borrow_q;
  logic                borrow_d;
  logic                load_err_q;
  logic                load_err_d;
  logic                all_zero;
  logic                run;

  assign all_zero = &is_zero;

  // Clamp the load value and form the borrow-lookahead decrement enables.
  always_comb begin
    ld_sat  = '0;
    nib_bad = '0;
    dec     = '0;
    run     = en & ~load;
    for (int i = 0; i < DIGITS; i++) begin
      ld_sat[4*i +: 4] = bcd_sat(load_val[4*i +: 4]);
      nib_bad[i]       = (load_val[4*i +: 4] > BCD_MAX);
      dec[i]           = run;
      run              = run & is_zero[i];
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_t wrap_val;

    // Only a whole-counter underflow takes the reload digit; inner borrows always wrap to 9.
    assign wrap_val = (AUTO_RELOAD && all_zero) ? reload_q[4*g +: 4] : BCD_MAX;

    m10_down_digit u_digit (
      .clk      (clk),
      .rst_n    (rst_n),
      .dec      (dec[g]),
      .load     (load),
      .ld_val   (ld_sat[4*g +: 4]),
      .wrap_val (wrap_val),
      .digit    (count[4*g +: 4]),
      .is_zero  (is_zero[g])
    );
  end

  // Next reload register and status pulses.
  always_comb begin
    reload_d   = reload_q;
    borrow_d   = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      reload_d   = ld_sat;
      load_err_d = |nib_bad;
    end else begin
      borrow_d = en & all_zero;
    end
  end

  // Reload register and registered status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload_q   <= '0;
      borrow_q   <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      reload_q   <= reload_d;
      borrow_q   <= borrow_d;
      load_err_q <= load_err_d;
    end
  end

  assign zero     = all_zero;
  assign borrow   = borrow_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed plus random bench for bcd_down_counter; one instance per AUTO_RELOAD setting.
module tb_bcd_down_counter;

  localparam int D    = 2;
  localparam int MAXV = 99;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         load;
  logic [7:0]   load_val;
  logic [7:0]   count_a;
  logic [7:0]   count_b;
  logic         zero_a;
  logic         zero_b;
  logic         borrow_a;
  logic         borrow_b;
  logic         load_err_a;
  logic         load_err_b;

  int checks = 0;
  int errors = 0;

  // Reference state, index 0 = wrap to all-9s, index 1 = auto reload
  int m_cnt [2];
  int m_rel [2];
  bit m_bor [2];
  bit m_err [2];

  bcd_down_counter #(.DIGITS(D), .AUTO_RELOAD(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val),
    .count(count_a), .zero(zero_a), .borrow(borrow_a), .load_err(load_err_a)
  );

  bcd_down_counter #(.DIGITS(D), .AUTO_RELOAD(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val),
    .count(count_b), .zero(zero_b), .borrow(borrow_b), .load_err(load_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[3:0] = 4'(v % 10);
    r[7:4] = 4'((v / 10) % 10);
    return r;
  endfunction

  function automatic int sat_val(input logic [7:0] v);
    int lo;
    int hi;
    lo = (int'(v[3:0]) > 9) ? 9 : int'(v[3:0]);
    hi = (int'(v[7:4]) > 9) ? 9 : int'(v[7:4]);
    return hi * 10 + lo;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      m_cnt[j] = 0;
      m_rel[j] = 0;
      m_bor[j] = 1'b0;
      m_err[j] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic l, input logic e, input logic [7:0] v);
    for (int j = 0; j < 2; j++) begin
      if (l) begin
        m_cnt[j] = sat_val(v);
        m_rel[j] = m_cnt[j];
        m_bor[j] = 1'b0;
        m_err[j] = (v[3:0] > 4'd9) || (v[7:4] > 4'd9);
      end else if (e) begin
        m_err[j] = 1'b0;
        if (m_cnt[j] == 0) begin
          m_bor[j] = 1'b1;
          m_cnt[j] = (j == 1) ? m_rel[j] : MAXV;
        end else begin
          m_bor[j] = 1'b0;
          m_cnt[j] = m_cnt[j] - 1;
        end
      end else begin
        m_bor[j] = 1'b0;
        m_err[j] = 1'b0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare();
    chk("count_wrap",    32'(count_a),    32'(to_bcd(m_cnt[0])));
    chk("zero_wrap",     32'(zero_a),     32'(m_cnt[0] == 0));
    chk("borrow_wrap",   32'(borrow_a),   32'(m_bor[0]));
    chk("loaderr_wrap",  32'(load_err_a), 32'(m_err[0]));
    chk("count_rld",     32'(count_b),    32'(to_bcd(m_cnt[1])));
    chk("zero_rld",      32'(zero_b),     32'(m_cnt[1] == 0));
    chk("borrow_rld",    32'(borrow_b),   32'(m_bor[1]));
    chk("loaderr_rld",   32'(load_err_b), 32'(m_err[1]));
  endtask

  task automatic step(input logic l, input logic e, input logic [7:0] v);
    load     = l;
    en       = e;
    load_val = v;
    @(posedge clk);
    model_edge(l, e, v);
    #1;
    compare();
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    load     = 1'b0;
    load_val = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare();
    rst_n = 1'b1;

    // Free-run from reset: underflow first, then 98, 97 ...
    repeat (4) step(1'b0, 1'b1, 8'h00);

    // Load 10 and count through the inner borrow down to the underflow
    step(1'b1, 1'b0, 8'h10);
    repeat (11) step(1'b0, 1'b1, 8'h00);

    // Reload cycle of 03
    step(1'b1, 1'b0, 8'h03);
    repeat (9) step(1'b0, 1'b1, 8'h00);

    // Non-BCD load clamps, then load beats underflow at 00
    step(1'b1, 1'b0, 8'h4C);
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h25);
    step(1'b1, 1'b0, 8'hF9);

    // Enable gaps hold the count
    step(1'b1, 1'b0, 8'h05);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h00);

    // Asynchronous reset while clock is low, mid-count at 37
    step(1'b1, 1'b0, 8'h37);
    load = 1'b0;
    en   = 1'b1;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare();
    @(posedge clk);
    #1;
    compare();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) step(1'b0, 1'b1, 8'h00);

    // Randomized traffic including non-BCD load values
    repeat (400) begin
      step(($urandom % 8) == 0, ($urandom % 4) != 0, 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
